// File: rtl/instr_encoder.sv
// Packs decoded RV32 instruction fields into raw words and streams them out
// with sequential word addresses; unencodable tuples are dropped and flagged.
module instr_encoder #(
    parameter int ADDR_W    = 32,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr_base,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_instr,
    output logic              err,
    output logic [7:0]        err_count,
    output logic              halted
);

    localparam int CNT_W = $clog2(MAX_WORDS + 1);
    localparam logic [CNT_W:0]   MAX_CNT  = (CNT_W + 1)'(MAX_WORDS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t            state;
    logic [CNT_W-1:0]  word_count;
    logic [ADDR_W-1:0] next_addr;

    logic              legal;
    logic [31:0]       packed_word;
    logic signed [31:0] simm;
    logic [CNT_W:0]    claimed;
    logic              has_budget;
    logic              accept;
    logic              xfer;
    logic              last_word;
    logic [ADDR_W-1:0] word_addr;

    assign simm = $signed(imm);

    always_comb begin
        legal       = 1'b0;
        packed_word = 32'd0;
        case (fmt)
            3'd0: begin
                legal       = 1'b1;
                packed_word = {funct7, rs2, rs1, funct3, rd, opcode};
            end
            3'd1: begin
                legal       = (simm >= -32'sd2048) && (simm <= 32'sd2047);
                packed_word = {imm[11:0], rs1, funct3, rd, opcode};
            end
            3'd2: begin
                legal       = (simm >= -32'sd2048) && (simm <= 32'sd2047);
                packed_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            end
            3'd3: begin
                legal       = (simm >= -32'sd4096) && (simm <= 32'sd4094) && !imm[0];
                packed_word = {imm[12], imm[10:5], rs2, rs1, funct3,
                               imm[4:1], imm[11], opcode};
            end
            3'd4: begin
                legal       = (imm[11:0] == 12'd0);
                packed_word = {imm[31:12], rd, opcode};
            end
            3'd5: begin
                legal       = (simm >= -32'sd1048576) && (simm <= 32'sd1048574) && !imm[0];
                packed_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            end
            default: begin
                legal       = 1'b0;
                packed_word = 32'd0;
            end
        endcase
    end

    // Words already counted plus the one sitting in the output register; once
    // that reaches MAX_WORDS no further tuple is taken, so HALT never strands a word.
    assign claimed    = {1'b0, word_count} + {{CNT_W{1'b0}}, out_valid};
    assign has_budget = (claimed < MAX_CNT);
    assign in_ready   = (state == RUN) && (!out_valid || out_ready) && has_budget;
    assign accept     = in_valid && in_ready;
    assign xfer       = out_valid && out_ready;
    assign last_word  = (word_count == LAST_CNT);
    assign word_addr  = start ? addr_base : next_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            word_count <= '0;
            next_addr  <= '0;
            out_valid  <= 1'b0;
            out_addr   <= '0;
            out_instr  <= 32'd0;
            err        <= 1'b0;
            err_count  <= 8'd0;
            halted     <= 1'b0;
        end else begin
            err <= accept && !legal;
            if (accept && !legal && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end

            // A pending word keeps its address across start; only an empty or
            // draining output register picks up the new base right away.
            if (accept && legal) begin
                out_valid <= 1'b1;
                out_instr <= packed_word;
                out_addr  <= word_addr;
                next_addr <= word_addr + ADDR_W'(4);
            end else begin
                if (xfer) begin
                    out_valid <= 1'b0;
                end
                if (start && (!out_valid || xfer)) begin
                    out_addr <= addr_base;
                end else if (xfer) begin
                    out_addr <= next_addr;
                end
                if (start) begin
                    next_addr <= addr_base;
                end
            end

            if (start) begin
                state      <= RUN;
                word_count <= '0;
                halted     <= 1'b0;
            end else if (xfer && (state == RUN)) begin
                word_count <= word_count + CNT_W'(1);
                if (last_word) begin
                    state  <= HALT;
                    halted <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed program fragments followed by
// randomized tuples checked against a field-arithmetic reference model.
module tb_instr_encoder;

    localparam int ADDR_W    = 32;
    localparam int MAX_WORDS = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] addr_base;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        fmt;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [31:0]       imm;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [31:0]       out_instr;
    logic              err;
    logic [7:0]        err_count;
    logic              halted;

    instr_encoder #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk(clk), .rst(rst), .start(start), .addr_base(addr_base),
        .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .opcode(opcode),
        .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2),
        .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_instr(out_instr), .err(err),
        .err_count(err_count), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
    } word_t;

    word_t expq[$];
    int    errq[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    logic [31:0] m_next = 32'd0;
    int    m_errs = 0;
    int    m_xfers = 0;
    logic  m_halted = 1'b0;
    logic  prev_stall = 1'b0;
    logic [31:0] prev_addr, prev_instr;
    int    bnd [20] = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095, 4096, -1048577,
                        -1048576, 1048574, 1048575, 1048576, 0, 1, -1, -3, 4, 4097};

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: what the RISC-V format tables say, in plain arithmetic.
    function automatic logic model_legal(input logic [2:0] f, input logic [31:0] im);
        int s;
        s = int'($signed(im));
        case (f)
            3'd0:       return 1'b1;
            3'd1, 3'd2: return (s >= -2048) && (s <= 2047);
            3'd3:       return (s >= -4096) && (s <= 4094) && (s % 2 == 0);
            3'd4:       return (im % 4096) == 0;
            3'd5:       return (s >= -1048576) && (s <= 1048574) && (s % 2 == 0);
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] model_word(input logic [2:0] f, input logic [6:0] op,
                                               input logic [2:0] f3, input logic [6:0] f7,
                                               input logic [4:0] d, input logic [4:0] s1,
                                               input logic [4:0] s2, input logic [31:0] im);
        logic [31:0] base_rs, w;
        base_rs = (32'(s2) << 20) | (32'(s1) << 15) | (32'(f3) << 12) | 32'(op);
        case (f)
            3'd0: w = (32'(f7) << 25) | base_rs | (32'(d) << 7);
            3'd1: w = ((im & 32'hFFF) << 20) | (32'(s1) << 15) | (32'(f3) << 12)
                      | (32'(d) << 7) | 32'(op);
            3'd2: w = (((im >> 5) & 32'h7F) << 25) | base_rs | ((im & 32'h1F) << 7);
            3'd3: w = (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | base_rs
                      | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7);
            3'd4: w = (im & 32'hFFFFF000) | (32'(d) << 7) | 32'(op);
            default: w = (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                      | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12)
                      | (32'(d) << 7) | 32'(op);
        endcase
        return w;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Stimulus side: every accepted tuple becomes an expected word or an expected err pulse.
    initial begin
        word_t w;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                expq.delete();
                errq.delete();
            end else begin
                if (start) m_next = addr_base;
                if (in_valid && in_ready) begin
                    if (model_legal(fmt, imm)) begin
                        w.addr  = m_next;
                        w.instr = model_word(fmt, opcode, funct3, funct7, rd, rs1, rs2, imm);
                        expq.push_back(w);
                        m_next += 32'd4;
                    end else begin
                        errq.push_back(cyc + 1);
                    end
                end
            end
        end
    end

    // Monitor side: compares whatever the DUT presents against the queues.
    initial begin
        word_t w;
        logic  exp_err;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                m_errs = 0;
                m_xfers = 0;
                m_halted = 1'b0;
                prev_stall = 1'b0;
            end else begin
                exp_err = (errq.size() > 0) && (errq[0] == cyc);
                if (exp_err) begin
                    void'(errq.pop_front());
                    if (m_errs < 255) m_errs++;
                end
                checkOutput("err", 32'(err), 32'(exp_err));
                checkOutput("err_count", 32'(err_count), 32'(m_errs));
                checkOutput("halted", 32'(halted), 32'(m_halted));
                if (prev_stall) begin
                    checkOutput("stall_valid", 32'(out_valid), 32'd1);
                    checkOutput("stall_addr", out_addr, prev_addr);
                    checkOutput("stall_instr", out_instr, prev_instr);
                end
                prev_stall = out_valid && !out_ready;
                prev_addr  = out_addr;
                prev_instr = out_instr;
                if (out_valid && out_ready) begin
                    if (expq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_word: got 0x%08h @0x%08h expected none",
                                 out_instr, out_addr);
                    end else begin
                        w = expq.pop_front();
                        checkOutput("word_addr", out_addr, w.addr);
                        checkOutput("word_instr", out_instr, w.instr);
                    end
                    m_xfers++;
                    if (m_xfers == MAX_WORDS) m_halted = 1'b1;
                end
                if (start) begin
                    m_xfers = 0;
                    m_halted = 1'b0;
                end
            end
        end
    end

    task automatic applyStimulus(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                                 input logic [4:0] s2, input logic [31:0] im, input logic ordy,
                                 output int waited);
        @(negedge clk);
        fmt = f; opcode = op; funct3 = f3; funct7 = f7;
        rd = d; rs1 = s1; rs2 = s2; imm = im;
        out_ready = ordy;
        in_valid = 1'b1;
        waited = 0;
        #4;
        while (!in_ready && waited <= 50) begin
            waited++;
            @(negedge clk);
            #4;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got in_ready=0 expected acceptance within 50 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic doStart(input logic [31:0] base);
        @(negedge clk);
        start = 1'b1;
        addr_base = base;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic randTuple();
        int sel;
        fmt = 3'($urandom_range(0, 7));
        opcode = 7'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
        rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
        sel = $urandom_range(0, 5);
        case (sel)
            0: imm = $urandom;
            1: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
            2: imm = 32'(bnd[$urandom_range(0, 19)]);
            3: imm = $urandom & 32'hFFFFF000;
            4: imm = (32'($urandom_range(0, 2097151)) - 32'd1048576) & 32'hFFFFFFFE;
            default: imm = (32'($urandom_range(0, 8191)) - 32'd4096) & 32'hFFFFFFFE;
        endcase
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got no finish expected finish before 400000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w;
        rst = 1'b1; start = 1'b0; addr_base = '0; in_valid = 1'b0; out_ready = 1'b0;
        fmt = '0; opcode = '0; funct3 = '0; funct7 = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
        repeat (2) @(negedge clk);
        #4;
        checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_err", 32'(err), 32'd0);
        checkOutput("reset_out_addr", out_addr, 32'd0);
        checkOutput("reset_out_instr", out_instr, 32'd0);
        checkOutput("reset_err_count", 32'(err_count), 32'd0);
        checkOutput("reset_halted", 32'(halted), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;

        doStart(32'h100);
        applyStimulus(3'd0, 7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd1, 32'd0, 1'b1, w);
        checkOutput("r_add_valid", 32'(out_valid), 32'd1);
        checkOutput("r_add_instr", out_instr, 32'h001100B3);
        checkOutput("r_add_addr", out_addr, 32'h100);

        doStart(32'h100);
        applyStimulus(3'd1, 7'h13, 3'd0, 7'd0, 5'd3, 5'd5, 5'd0, 32'd4, 1'b1, w);
        checkOutput("addi_wait", 32'(w), 32'd0);
        checkOutput("addi_instr", out_instr, 32'h00428193);
        applyStimulus(3'd5, 7'h6F, 3'd0, 7'd0, 5'd6, 5'd0, 5'd0, 32'd16, 1'b1, w);
        checkOutput("jal_wait", 32'(w), 32'd0);
        checkOutput("jal_instr", out_instr, 32'h0100036F);
        applyStimulus(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd10, 32'd8, 1'b1, w);
        checkOutput("sw_wait", 32'(w), 32'd0);
        checkOutput("sw_instr", out_instr, 32'h00A0A423);
        checkOutput("sw_addr", out_addr, 32'h108);

        doStart(32'h100);
        applyStimulus(3'd3, 7'h63, 3'd5, 7'd0, 5'd0, 5'd3, 5'd4, 32'hFFFFFFFC, 1'b1, w);
        checkOutput("bge_instr", out_instr, 32'hFE41DEE3);
        applyStimulus(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFD, 1'b1, w);
        applyStimulus(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd1, 5'd0, 32'd2048, 1'b1, w);
        @(negedge clk);
        #4;
        checkOutput("illegal_err_count", 32'(err_count), 32'd2);
        checkOutput("illegal_no_word", 32'(out_valid), 32'd0);
        checkOutput("illegal_addr_held", out_addr, 32'h104);

        doStart(32'h200);
        applyStimulus(3'd0, 7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd1, 32'd0, 1'b0, w);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #4;
            checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
            checkOutput("stall_held_addr", out_addr, 32'h200);
            checkOutput("stall_held_instr", out_instr, 32'h001100B3);
        end
        applyStimulus(3'd1, 7'h13, 3'd0, 7'd0, 5'd3, 5'd5, 5'd0, 32'd4, 1'b1, w);
        checkOutput("release_wait", 32'(w), 32'd0);
        checkOutput("release_next_addr", out_addr, 32'h204);

        doStart(32'h300);
        for (int i = 0; i < MAX_WORDS; i++) begin
            applyStimulus(3'd0, 7'h33, 3'd0, 7'd0, 5'(i + 1), 5'd2, 5'd3, 32'd0, 1'b1, w);
        end
        @(posedge clk);
        #1;
        fmt = 3'd0; opcode = 7'h33; imm = 32'd0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #4;
            checkOutput("halt_in_ready", 32'(in_ready), 32'd0);
            checkOutput("halt_flag", 32'(halted), 32'd1);
        end
        in_valid = 1'b0;
        doStart(32'h0);
        applyStimulus(3'd4, 7'h37, 3'd0, 7'd0, 5'd7, 5'd0, 5'd0, 32'hABCDE000, 1'b1, w);
        checkOutput("restart_addr", out_addr, 32'h0);
        checkOutput("restart_instr", out_instr, 32'hABCDE3B7);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            randTuple();
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 4) != 0;
            start     = (halted && ($urandom % 4 == 0)) || ($urandom % 300 == 0);
            addr_base = $urandom & 32'hFFFFFFFC;
        end
        @(negedge clk);
        in_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
        repeat (10) @(negedge clk);
        #4;
        checkOutput("drain_words_left", 32'(expq.size()), 32'd0);
        checkOutput("drain_errs_left", 32'(errq.size()), 32'd0);

        doStart(32'h500);
        applyStimulus(3'd6, 7'h13, 3'd0, 7'd0, 5'd1, 5'd1, 5'd0, 32'd0, 1'b0, w);
        applyStimulus(3'd0, 7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd1, 32'd0, 1'b0, w);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_err_count", 32'(err_count), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_out_addr", out_addr, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #4;
        checkOutput("idle_in_ready", 32'(in_ready), 32'd0);
        checkOutput("idle_out_valid", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
